// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI master arbiter: transaction state encoding.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_COMPLETE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or above the pointer,
// wrapping, returned both as one-hot and as an index.
module spi_arbiter_rr_pick
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [PTR_W-1:0]     off;
  logic [PTR_W:0]       idx_sum;
  logic [PTR_W:0]       idx_wrap;

  // Rotate the request vector so the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_i;
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      off = req_dbl[k] ? PTR_W'(k) : off;
    end
    idx_sum  = {1'b0, ptr_i} + {1'b0, off};
    idx_wrap = (idx_sum >= NUM_REQ_W) ? (idx_sum - NUM_REQ_W) : idx_sum;
    idx_o    = idx_wrap[PTR_W-1:0];
    valid_o  = |req_i;
    onehot_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, with
// send/ready handshaking, return-word capture and per-wait-state timeout.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int SIZE     = 40,
  parameter int CS_IDX_W = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk_in,
  input  logic                       reset_n_in,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [NUM_REQ*CS_IDX_W-1:0] req_cs_in,
  input  logic [NUM_REQ*SIZE-1:0]    req_data_in,
  output logic [NUM_REQ-1:0]         r_grant_out,
  output logic [NUM_REQ-1:0]         r_done_out,
  output logic                       r_error_out,
  output logic [SIZE-1:0]            r_data_out,
  output logic                       r_busy_out,
  output logic [SIZE-1:0]            r_spi_data_out,
  output logic [CS_IDX_W-1:0]        r_spi_cs_out,
  output logic                       r_spi_send_out,
  input  logic [SIZE-1:0]            spi_data_in,
  input  logic                       spi_ready_in
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 error_q, error_d;
  logic [SIZE-1:0]      data_q, data_d;
  logic                 busy_q, busy_d;
  logic [SIZE-1:0]      spi_data_q, spi_data_d;
  logic [CS_IDX_W-1:0]  cs_q, cs_d;
  logic                 send_q, send_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 cnt_expired;

  spi_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_i    (req_in),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    done_d      = '0;
    error_d     = 1'b0;
    data_d      = data_q;
    spi_data_d  = spi_data_q;
    cs_d        = cs_q;
    send_d      = send_q;
    cnt_expired = (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (pick_valid && spi_ready_in) begin
          grant_d    = pick_onehot;
          cs_d       = req_cs_in[int'(pick_idx)*CS_IDX_W +: CS_IDX_W];
          spi_data_d = req_data_in[int'(pick_idx)*SIZE +: SIZE];
          send_d     = 1'b1;
          ptr_d      = (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);
          cnt_d      = '0;
          state_d    = ST_WAIT_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_BUSY: begin
        if (cnt_expired) begin
          send_d  = 1'b0;
          done_d  = grant_q;
          error_d = 1'b1;
          state_d = ST_COMPLETE;
        end else if (!spi_ready_in) begin
          send_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (cnt_expired) begin
          done_d  = grant_q;
          error_d = 1'b1;
          state_d = ST_COMPLETE;
        end else if (spi_ready_in) begin
          data_d  = spi_data_in;
          done_d  = grant_q;
          state_d = ST_COMPLETE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMPLETE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        send_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops send and grant immediately.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      error_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      spi_data_q <= '0;
      cs_q       <= '0;
      send_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      error_q    <= error_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      spi_data_q <= spi_data_d;
      cs_q       <= cs_d;
      send_q     <= send_d;
    end
  end

  assign r_grant_out    = grant_q;
  assign r_done_out     = done_q;
  assign r_error_out    = error_q;
  assign r_data_out     = data_q;
  assign r_busy_out     = busy_q;
  assign r_spi_data_out = spi_data_q;
  assign r_spi_cs_out   = cs_q;
  assign r_spi_send_out = send_q;

endmodule
